// File: rtl/cronometro_ctrl_if.sv
// Button / count-register / display handshake of the stopwatch controller.
// master drives the raw buttons and cont_max; slave is the controller itself.
interface cronometro_ctrl_if;
    logic       botao0;
    logic       botao1;
    logic       botao2;
    logic       botao3;
    logic       cont_max;
    logic [1:0] estado;
    logic       conta_en;
    logic       zera;
    logic       congela;

    modport master (
        output botao0, botao1, botao2, botao3, cont_max,
        input  estado, conta_en, zera, congela
    );

    modport slave (
        input  botao0, botao1, botao2, botao3, cont_max,
        output estado, conta_en, zera, congela
    );
endinterface

// File: rtl/cronometro_ctrl.sv
// Stopwatch control sequencer: button debouncing, mode FSM and timebase prescaler
// driving the count register (conta_en/zera) and the display freeze flag (congela).
module cronometro_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_DIV        = 500000
) (
    input  logic               clk,
    input  logic               reset,
    cronometro_ctrl_if.slave   bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        VOLTA    = 2'b11
    } estado_t;

    // Bit order everywhere: [0] INICIAR, [1] PAUSAR, [2] ZERAR, [3] VOLTA
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [3:0]    deb_prev;
    logic [3:0]    ev;
    logic [DW-1:0] deb_cnt [4];

    assign raw = {bus.botao3, bus.botao2, bus.botao1, bus.botao0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            // NOTE: the counter array is tiny flops, not RAM, so resetting it is free
            // and guarantees a held button needs a fresh full debounce after reset.
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage chain.
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign ev = deb & ~deb_prev;

    logic ev_iniciar;
    logic ev_pausar;
    logic ev_zerar;
    logic ev_volta;

    assign ev_iniciar = ev[0];
    assign ev_pausar  = ev[1];
    assign ev_zerar   = ev[2];
    assign ev_volta   = ev[3];

    estado_t       estado_q;
    estado_t       estado_d;
    logic [PW-1:0] pres_q;
    logic [PW-1:0] pres_d;
    logic          zera_q;
    logic          zera_d;
    logic          conta_q;
    logic          conta_d;
    logic          running;
    logic          tick;
    logic          saturado;

    assign running  = (estado_q == CONTANDO) || (estado_q == VOLTA);
    assign tick     = running && (pres_q == TICK_LAST);
    assign saturado = tick && bus.cont_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= PARADO;
            pres_q   <= '0;
            zera_q   <= 1'b0;
            conta_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pres_q   <= pres_d;
            zera_q   <= zera_d;
            conta_q  <= conta_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        estado_d = estado_q;
        pres_d   = pres_q;
        zera_d   = 1'b0;
        conta_d  = 1'b0;

        if (running) pres_d = tick ? '0 : pres_q + 1'b1;

        if (ev_zerar) begin
            estado_d = PARADO;
            zera_d   = 1'b1;
        end else begin
            case (estado_q)
                PARADO:   if (ev_iniciar) estado_d = CONTANDO;
                CONTANDO: begin
                    if (ev_pausar || saturado) estado_d = PAUSADO;
                    else if (ev_volta)         estado_d = VOLTA;
                end
                VOLTA: begin
                    if (ev_pausar || saturado) estado_d = PAUSADO;
                    else if (ev_volta)         estado_d = CONTANDO;
                end
                PAUSADO:  if (ev_iniciar) estado_d = CONTANDO;
                default:  estado_d = PARADO;
            endcase
        end

        // Leaving PARADO always starts a fresh 1/100 s period
        if ((estado_q == PARADO) || ev_zerar) pres_d = '0;

        // A clear on the same cycle as a tick swallows the increment
        conta_d = tick && !bus.cont_max && !ev_zerar;
    end

    assign bus.estado   = estado_q;
    assign bus.conta_en = conta_q;
    assign bus.zera     = zera_q;
    assign bus.congela  = (estado_q == VOLTA);

endmodule
